// File: rtl/expo_pkg.sv
// expo_pkg: shared widths and loader state for the Montgomery exponentiation datapath.
package expo_pkg;
    localparam int OP_W = 192;
    localparam int WORD_W = 32;
    localparam int NWORDS = OP_W / WORD_W;
    localparam int CNT_W = $clog2(NWORDS);
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, FIRE, WAIT} loader_state_t;
endpackage

// File: rtl/expo_operand_loader_if.sv
// expo_operand_loader_if: word stream feeding the operand loader.
interface expo_operand_loader_if;
    import expo_pkg::*;
    logic [WORD_W-1:0] in_data;
    logic in_valid;
    logic in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/expo_operand_loader.sv
// expo_operand_loader: assembles x then y from a word stream, fires the core once, waits for done.
module expo_operand_loader
    import expo_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    expo_operand_loader_if.slave  src,
    input  logic                  flush,
    input  logic                  expo_done,
    output logic [OP_W-1:0]       x_out,
    output logic [OP_W-1:0]       y_out,
    output logic                  start,
    output logic                  busy
);
    loader_state_t state;
    logic [CNT_W-1:0] cnt;
    logic done_q;
    logic last;
    logic done_rise;
    assign src.in_ready = (state == LOAD_X) || (state == LOAD_Y);
    assign last = cnt == CNT_W'(NWORDS - 1);
    // done_q tracks expo_done in every state, so a level already high before WAIT is not an edge
    assign done_rise = expo_done && !done_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            x_out <= '0;
            y_out <= '0;
            start <= 1'b0;
            busy <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= expo_done;
            start <= 1'b0;
            case (state)
                IDLE: state <= LOAD_X;
                LOAD_X, LOAD_Y: begin
                    if (flush) begin
                        state <= LOAD_X;
                        cnt <= '0;
                        x_out <= '0;
                        y_out <= '0;
                    end else if (src.in_valid) begin
                        if (state == LOAD_X) x_out[WORD_W*cnt +: WORD_W] <= src.in_data;
                        else y_out[WORD_W*cnt +: WORD_W] <= src.in_data;
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) begin
                            state <= (state == LOAD_X) ? LOAD_Y : FIRE;
                            start <= state == LOAD_Y;
                            busy <= state == LOAD_Y;
                        end
                    end
                end
                FIRE: state <= WAIT;
                WAIT: begin
                    if (done_rise) begin
                        state <= LOAD_X;
                        cnt <= '0;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_expo_operand_loader.sv
// tb_expo_operand_loader: randomized scoreboard bench for the operand loader.
module tb_expo_operand_loader;
    import expo_pkg::*;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_FIRE = 2, PH_WAIT = 3;
    typedef struct packed {
        logic [OP_W-1:0] x;
        logic [OP_W-1:0] y;
    } pair_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic expo_done = 1'b0;
    logic [OP_W-1:0] x_out, y_out;
    logic start, busy;
    int n_checks = 0;
    int n_fail = 0;
    expo_operand_loader_if bus();
    expo_operand_loader dut (
        .clk(clk), .reset(reset), .src(bus), .flush(flush), .expo_done(expo_done),
        .x_out(x_out), .y_out(y_out), .start(start), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Reference model: words collected per operand set, expected outputs and load phase
    int ph;
    logic [WORD_W-1:0] words[$];
    logic [OP_W-1:0] mx, my;
    logic prev_done;
    pair_t sb[$];
    pair_t got;
    function automatic pair_t assemble();
        pair_t p = '0;
        for (int i = NWORDS - 1; i >= 0; i--) begin
            p.x = (p.x << WORD_W) | OP_W'(words[i]);
            p.y = (p.y << WORD_W) | OP_W'(words[i + NWORDS]);
        end
        return p;
    endfunction
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_x", x_out, '0);
            chk("rst_y", y_out, '0);
            chk("rst_start", start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", bus.in_ready, 0);
            ph = PH_IDLE;
            words.delete();
            sb.delete();
            mx = '0;
            my = '0;
            prev_done = 1'b0;
        end else begin
            chk("in_ready", bus.in_ready, ph == PH_LOAD);
            chk("start", start, ph == PH_FIRE);
            chk("busy", busy, ph == PH_FIRE || ph == PH_WAIT);
            chk("x_out", x_out, mx);
            chk("y_out", y_out, my);
            if (start) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_pending: got start with no completed operand set");
                end else begin
                    got = sb.pop_front();
                    chk("sb_x", x_out, got.x);
                    chk("sb_y", y_out, got.y);
                end
            end
            case (ph)
                PH_IDLE: ph = PH_LOAD;
                PH_LOAD: begin
                    if (flush) begin
                        words.delete();
                        mx = '0;
                        my = '0;
                    end else if (bus.in_valid) begin
                        if (words.size() < NWORDS) mx[WORD_W*words.size() +: WORD_W] = bus.in_data;
                        else my[WORD_W*(words.size() - NWORDS) +: WORD_W] = bus.in_data;
                        words.push_back(bus.in_data);
                        if (words.size() == 2 * NWORDS) begin
                            sb.push_back(assemble());
                            words.delete();
                            ph = PH_FIRE;
                        end
                    end
                end
                PH_FIRE: ph = PH_WAIT;
                default: if (expo_done && !prev_done) ph = PH_LOAD;
            endcase
            prev_done = expo_done;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic put(input logic [WORD_W-1:0] w);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = w;
        while (!bus.in_ready && n < 1000) begin
            tick();
            n++;
        end
        chk("put_ready", bus.in_ready, 1);
        tick();
    endtask
    task automatic wait_start(input string name);
        int n = 0;
        while (!start && n < 100) begin
            tick();
            n++;
        end
        chk(name, start, 1);
    endtask
    task automatic pulse_done(input int len);
        expo_done = 1'b1;
        repeat (len) tick();
        expo_done = 1'b0;
    endtask
    task automatic load12_random();
        for (int i = 0; i < 2 * NWORDS; i++) put($urandom);
        bus.in_valid = 1'b0;
    endtask
    logic [WORD_W-1:0] t1 [12] = '{32'hedcba987, 32'h6543210f, 32'hedcba987, 32'h6543210f,
                                   32'hedcba987, 32'h6543210f, 32'h76543210, 32'hfedcba98,
                                   32'h76543210, 32'hfedcba98, 32'h76543210, 32'hfedcba98};
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        int k;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) put(t1[i]);
        wait_start("t1_start");
        chk("t1_x", x_out, 192'h6543210fedcba9876543210fedcba9876543210fedcba987);
        chk("t1_y", y_out, 192'hfedcba9876543210fedcba9876543210fedcba9876543210);
        chk("t1_busy", busy, 1);
        repeat (200) tick();
        chk("t2_ready", bus.in_ready, 0);
        pulse_done(1);
        chk("t2_rearm", bus.in_ready, 1);
        put(32'h1);
        chk("t2_word0", x_out[WORD_W-1:0], 32'h1);
        bus.in_valid = 1'b0;
        tick();
        put(32'h2);
        bus.in_valid = 1'b0;
        tick();
        put(32'h3);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hdeadbeef;
        tick();
        flush = 1'b0;
        chk("t3_flushed_x", x_out, '0);
        for (int i = 0; i < 12; i++) put((i % NWORDS == 0) ? 32'h3 : 32'h0);
        bus.in_valid = 1'b0;
        wait_start("t3_start");
        chk("t3_x", x_out, 192'h3);
        chk("t3_y", y_out, 192'h3);
        repeat (20) tick();
        pulse_done(1);
        for (int i = 0; i < 8; i++) put($urandom);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t4_async_x", x_out, '0);
        chk("t4_async_y", y_out, '0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_ready", bus.in_ready, 0);
        tick();
        reset = 1'b0;
        chk("t4_idle_ready", bus.in_ready, 0);
        tick();
        chk("t4_load_ready", bus.in_ready, 1);
        load12_random();
        wait_start("t4b_start");
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("t4b_async_busy", busy, 0);
        chk("t4b_async_start", start, 0);
        chk("t4b_async_x", x_out, '0);
        tick();
        reset = 1'b0;
        tick();
        expo_done = 1'b1;
        load12_random();
        wait_start("t5_start");
        repeat (30) tick();
        chk("t5_level_ready", bus.in_ready, 0);
        chk("t5_level_busy", busy, 1);
        expo_done = 1'b0;
        repeat (2) tick();
        expo_done = 1'b1;
        tick();
        chk("t5_rearm", bus.in_ready, 1);
        load12_random();
        wait_start("t5b_start");
        repeat (30) tick();
        chk("t5b_held_busy", busy, 1);
        expo_done = 1'b0;
        tick();
        pulse_done(1);
        repeat (8) begin
            k = 0;
            while (k < 2 * NWORDS) begin
                case ($urandom_range(0, 9))
                    0, 1: begin
                        bus.in_valid = 1'b0;
                        tick();
                    end
                    2: begin
                        flush = 1'b1;
                        bus.in_valid = 1'($urandom);
                        bus.in_data = $urandom;
                        tick();
                        flush = 1'b0;
                        k = 0;
                    end
                    default: begin
                        put($urandom);
                        k++;
                    end
                endcase
            end
            bus.in_valid = 1'($urandom);
            wait_start("rnd_start");
            repeat ($urandom_range(3, 40)) tick();
            pulse_done($urandom_range(1, 4));
        end
        bus.in_valid = 1'b0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/expo_operand_loader.md
Name: expo_operand_loader

Overview:
- Word-serial front end for the 192-bit Montgomery exponentiation core.
- Accepts WORD_W-bit words over a valid/ready stream and assembles operand x, then operand y.
- Drives the core's x/y inputs and issues a single-cycle start.
- Holds off further input until the core's done output rises, then re-arms for the next operand set.

Parameters:
- OP_W, 192, operand width in bits; must equal the core's x/y width.
- WORD_W, 32, input word width; OP_W must be an integer multiple of WORD_W.
- NWORDS, OP_W/WORD_W (derived localparam, 6), words per operand.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  WORD_W  operand word.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts a word this cycle.
- flush  in  1  synchronous abort of a partial load.
- expo_done  in  1  done output of the exponentiation core; level or pulse.
- x_out  out  OP_W  assembled x, to core x.
- y_out  out  OP_W  assembled y, to core y.
- start  out  1  one-cycle start pulse to the core.
- busy  out  1  high from the start pulse until expo_done rises.

Behaviour:
- Transfer rule: a word is accepted on a rising clk edge with in_valid=1 and in_ready=1. in_valid=0 cycles (bubbles) change nothing.
- FSM states: IDLE, LOAD_X, LOAD_Y, FIRE, WAIT. Word counter cnt is 0..NWORDS-1, width clog2(NWORDS).
- Reset (async, any state, including mid-load or WAIT):
  - state=IDLE, cnt=0, x_out=0, y_out=0.
  - start=0, busy=0, in_ready=0, done_q=0.
- IDLE -> LOAD_X unconditionally on the next edge.
- in_ready = (state==LOAD_X || state==LOAD_Y). It is decoded from the registered state and never depends combinationally on in_valid.
- LOAD_X:
  - The accepted word with index cnt is written to x_out[WORD_W*cnt +: WORD_W]. Word 0 is the least-significant word.
  - cnt increments on each accept. When cnt==NWORDS-1 is accepted: cnt=0, go to LOAD_Y.
- LOAD_Y:
  - Same placement rule into y_out.
  - When cnt==NWORDS-1 is accepted: go to FIRE.
- FIRE:
  - start=1 for exactly this one cycle, which is the cycle after the last y word is accepted.
  - busy=1. Go to WAIT.
- WAIT:
  - busy=1, in_ready=0.
  - done_q registers expo_done every cycle, in all states.
  - On a rising edge (expo_done=1 && done_q=0): go to LOAD_X with cnt=0. busy falls on the same edge.
  - A level-high expo_done present at entry to WAIT must not trigger re-arm. done_q is updated during FIRE, so a level held high from the previous operation produces no edge.
- Output hold: x_out and y_out do not change from FIRE until the first new x word is accepted after re-arm. The core sees stable operands for the whole operation.
- flush:
  - In LOAD_X/LOAD_Y: cnt=0, go to LOAD_X, x_out=0, y_out=0.
  - flush together with an accept: flush wins and the word is discarded.
  - Ignored in IDLE, FIRE and WAIT; a running operation cannot be aborted except by reset.
- start is registered (a state-decoded flop). It is never high in two consecutive cycles.
- No overflow or underflow is possible: words offered while in_ready=0 are simply not taken.

Decomposition:
- Shared package expo_pkg holds:
  - OP_W=192, WORD_W=32, NWORDS.
  - The loader state enum (IDLE, LOAD_X, LOAD_Y, FIRE, WAIT).
  - Also used by the core and the future result unloader.
- Single module, no sub-module. The rising-edge detector on expo_done is two lines of inline logic.

Test Plan:
1. Normal load.
   - Stimulus, LS word first, valid every cycle: edcba987, 6543210f, edcba987, 6543210f, edcba987, 6543210f, then 76543210, fedcba98, 76543210, fedcba98, 76543210, fedcba98.
   - Required: x_out=192'h6543210fedcba9876543210fedcba9876543210fedcba987 and y_out=192'hfedcba9876543210fedcba9876543210fedcba9876543210.
   - Required: start high exactly one cycle, the cycle after the 12th accept; busy=1.
2. Backpressure in WAIT.
   - Stimulus: in_valid held high after the 12th word, expo_done pulsed 1 cycle after 200 cycles.
   - Required: in_ready=0 and x_out/y_out unchanged through WAIT. in_ready=1 the cycle after the done edge. The next word lands in x_out[31:0].
3. Bubbles and flush.
   - Stimulus: in_valid toggled 1/0 across 3 x words, then flush together with a 4th word, then a full clean load of x=3, y=3.
   - Required: x_out=3, y_out=3, single start. The flushed-cycle word does not appear.
4. Reset mid-operation.
   - Stimulus: reset asserted after 8 accepted words, and separately during WAIT.
   - Required: asynchronously x_out=0, y_out=0, start=0, busy=0, in_ready=0. LOAD_X with in_ready=1 two cycles after release.
5. Level done.
   - Stimulus: expo_done held high continuously from before FIRE, or held high after completion.
   - Required: exactly one re-arm per rising edge. No second start until 12 new words are accepted.
